// File: rtl/exponent_bit_streamer.sv
// Loads an exponent as REGISTER_SIZE-bit blocks (least-significant block first), then presents
// it one bit at a time MSB first, advancing on each downstream consume pulse.
module exponent_bit_streamer #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned BITS_IN_N     = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     load_valid_in,
  input  logic [REGISTER_SIZE-1:0] load_block_in,
  output logic                     load_ready_out,
  input  logic                     consumed_in,
  output logic                     n_bit_out,
  output logic                     bit_valid_out,
  output logic                     last_bit_out,
  output logic                     done_out
);

  localparam int unsigned NB   = BITS_IN_N / REGISTER_SIZE;
  localparam int unsigned CntW = $clog2(NB + 1);
  localparam int unsigned PtrW = (BITS_IN_N > 1) ? $clog2(BITS_IN_N) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(NB - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(NB);
  localparam logic [PtrW-1:0] PtrTop  = PtrW'(BITS_IN_N - 1);

  typedef enum logic [1:0] {
    StLoading,
    StStreaming,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      blk_idx;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [BITS_IN_N-1:0] store_q;
  logic                 accept;
  logic                 n_bit_q, n_bit_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    n_bit_d = n_bit_q;
    accept  = load_valid_in && (state_q != StStreaming);
    // A block accepted in DONE starts a fresh exponent at block 0.
    blk_idx = (state_q == StDone) ? '0 : cnt_q;

    unique case (state_q)
      StLoading, StDone: begin
        if (load_valid_in) begin
          if (blk_idx == CntLast) begin
            state_d = StStreaming;
            cnt_d   = CntFull;
            ptr_d   = PtrTop;
            // Top bit of the final block is exponent bit BITS_IN_N-1.
            n_bit_d = load_block_in[REGISTER_SIZE-1];
          end else begin
            state_d = StLoading;
            cnt_d   = blk_idx + 1'b1;
            n_bit_d = 1'b0;
          end
        end
      end
      StStreaming: begin
        if (consumed_in) begin
          if (ptr_q == '0) begin
            state_d = StDone;
            n_bit_d = 1'b0;
          end else begin
            ptr_d   = ptr_q - 1'b1;
            n_bit_d = store_q[ptr_q - 1'b1];
          end
        end
      end
      default: state_d = StLoading;
    endcase

    ready_d = (state_d != StStreaming);
    valid_d = (state_d == StStreaming);
    done_d  = (state_d == StDone);
    last_d  = valid_d && (ptr_d == '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StLoading;
      cnt_q   <= '0;
      ptr_q   <= PtrTop;
      n_bit_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      n_bit_q <= n_bit_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Exponent storage is deliberately not reset; a new load overwrites it.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      store_q[blk_idx * REGISTER_SIZE +: REGISTER_SIZE] <= load_block_in;
    end
  end

  assign load_ready_out = ready_q;
  assign n_bit_out      = n_bit_q;
  assign bit_valid_out  = valid_q;
  assign last_bit_out   = last_q;
  assign done_out       = done_q;

endmodule

// File: tb/tb_exponent_bit_streamer.sv
// Directed sequence of loads and randomized-gap streams checked against a reference exponent vector.
module tb_exponent_bit_streamer;

  localparam int RS = 32;
  localparam int BN = 2048;
  localparam int NB = BN / RS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0;
  logic [RS-1:0] load_block = '0;
  logic          consumed = 1'b0;
  logic          ready, n_bit, valid, last, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [RS-1:0] blk [NB];
  logic [BN-1:0] model = '0;

  exponent_bit_streamer #(
    .REGISTER_SIZE(RS),
    .BITS_IN_N    (BN)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .load_valid_in (load_valid),
    .load_block_in (load_block),
    .load_ready_out(ready),
    .consumed_in   (consumed),
    .n_bit_out     (n_bit),
    .bit_valid_out (valid),
    .last_bit_out  (last),
    .done_out      (done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_ready, input logic e_valid,
                          input logic e_bit, input logic e_last, input logic e_done);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, e_ready});
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    chk({tag, ".bit"},   {31'd0, n_bit}, {31'd0, e_bit});
    chk({tag, ".last"},  {31'd0, last},  {31'd0, e_last});
    chk({tag, ".done"},  {31'd0, done},  {31'd0, e_done});
  endtask

  // Asserted off the clock edge; outputs must reach reset values without a clock.
  task automatic do_reset(input string tag);
    rst        = 1'b1;
    load_valid = 1'b0;
    consumed   = 1'b0;
    #1;
    chk_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    step;
    rst = 1'b0;
  endtask

  // Loads blk[0..n-1]; idle gap cycles carry consume pulses and junk data that must be ignored.
  task automatic load(input int n, input int gap, input bit from_done);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        load_valid = 1'b0;
        load_block = $urandom;
        consumed   = 1'($urandom_range(0, 1));
        step;
        consumed = 1'b0;
        chk_outs($sformatf("ldgap%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, from_done && (k == 0));
      end
      load_valid = 1'b1;
      load_block = blk[k];
      step;
      load_valid = 1'b0;
      model[k*RS +: RS] = blk[k];
      if (k < NB - 1) chk_outs($sformatf("ld%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else            chk_outs("ldlast", 1'b0, 1'b1, blk[NB-1][RS-1], 1'b0, 1'b0);
    end
  endtask

  task automatic chk_bit(input int i);
    chk_outs($sformatf("str%0d", i), 1'b0, 1'b1, model[i], i == 0, 1'b0);
  endtask

  // Consumes nbits bits MSB first; idle cycles offer loads that must be ignored.
  task automatic stream(input int nbits, input int maxgap);
    for (int j = 0; j < nbits; j++) begin
      int i;
      int gap;
      i   = BN - 1 - j;
      gap = int'($urandom_range(0, maxgap));
      chk_bit(i);
      for (int g = 0; g < gap; g++) begin
        load_valid = 1'($urandom_range(0, 1));
        load_block = $urandom;
        step;
        load_valid = 1'b0;
        chk_bit(i);
      end
      consumed = 1'b1;
      step;
      consumed = 1'b0;
    end
    if (nbits == BN) chk_outs("done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset("rst0");

    // Single set bit at the very top of the exponent.
    for (int k = 0; k < NB; k++) blk[k] = '0;
    blk[NB-1] = 32'h8000_0000;
    load(NB, 0, 1'b0);
    stream(BN, 2);

    // DONE ignores consume pulses.
    for (int c = 0; c < 3; c++) begin
      consumed = 1'b1;
      step;
      consumed = 1'b0;
      chk_outs("doneidle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // New exponent loaded straight from DONE: only bit 0 set.
    for (int k = 0; k < NB; k++) blk[k] = '0;
    blk[0] = 32'h0000_0001;
    load(NB, 1, 1'b1);
    stream(BN, 2);

    // Block k = k, valid every third cycle, long random consume gaps.
    do_reset("rst1");
    for (int k = 0; k < NB; k++) blk[k] = 32'(k);
    load(NB, 2, 1'b0);
    stream(BN, 5);

    // Reset part way through a load, then all-ones exponent.
    do_reset("rst2");
    for (int k = 0; k < NB; k++) blk[k] = $urandom;
    load(30, 1, 1'b0);
    #3;
    do_reset("rstload");
    for (int k = 0; k < NB; k++) blk[k] = 32'hFFFF_FFFF;
    load(NB, 0, 1'b0);
    stream(BN, 0);

    // Reset part way through a stream, then a random exponent.
    for (int k = 0; k < NB; k++) blk[k] = $urandom;
    load(NB, 0, 1'b1);
    stream(100, 1);
    #2;
    do_reset("rststream");
    for (int k = 0; k < NB; k++) blk[k] = $urandom;
    load(NB, 1, 1'b0);
    stream(BN, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exponent_bit_streamer.md
EXPONENT_BIT_STREAMER -- requirements
Module: exponent_bit_streamer

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, width of one load block.
REQ-002 SHALL have parameter BITS_IN_N, default 2048, exponent length in bits; a multiple of REGISTER_SIZE.
REQ-003 SHALL have port clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load_valid_in  input  1  load_block_in carries a valid exponent block this cycle.
REQ-006 SHALL have port load_block_in  input  REGISTER_SIZE  exponent block; least-significant block first.
REQ-007 SHALL have port load_ready_out  output  1  block may be accepted this cycle.
REQ-008 SHALL have port consumed_in  input  1  single-cycle pulse from downstream accumulator; current bit used.
REQ-009 SHALL have port n_bit_out  output  1  current exponent bit.
REQ-010 SHALL have port bit_valid_out  output  1  n_bit_out is meaningful.
REQ-011 SHALL have port last_bit_out  output  1  n_bit_out is exponent bit 0.
REQ-012 SHALL have port done_out  output  1  all BITS_IN_N bits consumed.

Function
REQ-013 SHALL store BITS_IN_N bits internally as NB = BITS_IN_N/REGISTER_SIZE blocks.
REQ-014 SHALL implement states LOADING, STREAMING, DONE.
REQ-015 LOADING: load_ready_out=1; a block is accepted when load_valid_in=1; the k-th accepted block (k=0..NB-1) is written to bits [k*REGISTER_SIZE +: REGISTER_SIZE].
REQ-016 After acceptance of block NB-1 in cycle t, SHALL enter STREAMING at t+1 with n_bit_out = bit BITS_IN_N-1 and bit_valid_out=1.
REQ-017 STREAMING: bits SHALL be presented MSB first (BITS_IN_N-1 down to 0); the bit pointer decrements once per consumed_in pulse; the next bit appears at the cycle after the pulse.
REQ-018 STREAMING: n_bit_out SHALL hold stable between consumed_in pulses, for any number of cycles.
REQ-019 last_bit_out SHALL be 1 exactly when in STREAMING and the pointer equals 0.
REQ-020 consumed_in while the pointer equals 0 SHALL enter DONE at the next cycle: bit_valid_out=0, done_out=1, n_bit_out=0.
REQ-021 load_ready_out SHALL be 0 in STREAMING; consumed_in SHALL be ignored in LOADING and DONE.
REQ-022 DONE: load_ready_out=1; an accepted block SHALL clear done_out next cycle, enter LOADING with load count 1, store that block as block 0 (new exponent load).
REQ-023 load_valid_in in STREAMING SHALL be ignored; no storage change.
REQ-024 Load counter and bit pointer SHALL never wrap: counter saturates at transition, pointer stops at 0.
REQ-025 Storage contents SHALL be retained after DONE until overwritten by a new load.

Reset
REQ-026 While rst_in=1, independent of clk_in: state LOADING, load count 0, pointer BITS_IN_N-1, load_ready_out=1, n_bit_out=0, bit_valid_out=0, last_bit_out=0, done_out=0.
REQ-027 Reset mid-load or mid-stream SHALL discard progress; the next load restarts at block 0; storage contents need not be cleared.
REQ-028 First accepted block SHALL be the one presented on the first rising edge after rst_in deasserts.

Verification
REQ-029 Load 64 blocks with block 63 = 0x8000_0000, others 0 -> next cycle bit_valid_out=1, n_bit_out=1; after 1 consumed_in, n_bit_out=0.
REQ-030 Load blocks k = k (0..63), pulse consumed_in 2048 times with random 0-5 idle-cycle gaps -> collected bit sequence equals stored 2048-bit value MSB first; last_bit_out=1 only during the final bit; done_out=1 one cycle after the 2048th pulse.
REQ-031 load_valid_in gapped (valid every 3rd cycle) -> exactly 64 blocks accepted; STREAMING entered cycle after 64th acceptance.
REQ-032 Assert rst_in asynchronously after 30 blocks loaded -> outputs at reset values immediately; a fresh 64-block load with all 0xFFFF_FFFF streams 2048 ones.
REQ-033 In DONE, load new exponent (block 0 = 0x1, others 0) -> done_out clears after first acceptance; streaming yields 2047 zeros then 1 with last_bit_out=1.
REQ-034 consumed_in pulses during LOADING and DONE, load_valid_in during STREAMING -> no pointer movement, no storage change.
